// File: rtl/ioexp_port_bank.sv
// I/O-expander register bank: NUM_PORTS 8-bit ports with debounced inputs, sticky interrupt
// status, read snapshot and an INT_N gap FSM. Define IOEXP_POLARITY_EN to add polarity registers.
//   state  | meaning
//   IDLE   | no status pending, INT_N released
//   ASSERT | status pending, INT_N driven low unless disabled
//   GAP    | just released; INT_N held high for GAP_CYCLES before it may re-assert
module ioexp_port_bank #(
    parameter int NUM_PORTS  = 2,
    parameter int DEB_CYCLES = 4,
    parameter int GAP_CYCLES = 2250
) (
    input  logic                   iClk,
    input  logic                   nrst,
    input  logic [7:0]             iOffset,
    input  logic                   iWrEn,
    input  logic [7:0]             iWrData,
    input  logic                   iRdEn,
    output logic [7:0]             oRdData,
    input  logic [8*NUM_PORTS-1:0] iPortIn,
    output logic [8*NUM_PORTS-1:0] oPortOut,
    input  logic                   iIntDisable_n,
    output logic                   oInt_n
);

    localparam logic [3:0]  NP  = 4'(NUM_PORTS);
    localparam logic [7:0]  DEB = 8'(DEB_CYCLES);
    localparam logic [15:0] GAP = 16'(GAP_CYCLES);

    localparam logic [4:0] BK_IN   = 5'd0;
    localparam logic [4:0] BK_OUT  = 5'd1;
    localparam logic [4:0] BK_POL  = 5'd2;
    localparam logic [4:0] BK_CFG  = 5'd3;
    localparam logic [4:0] BK_MASK = 5'd4;
    localparam logic [4:0] BK_STAT = 5'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_GAP} state_t;

    logic [NUM_PORTS-1:0][7:0] sync1_q, sync2_q, deb_last_q, deb_cnt_q, filt_q;
    logic [NUM_PORTS-1:0][7:0] out_q, cfg_q, mask_q, stat_q, snap_q, pol_v;
    logic [NUM_PORTS-1:0]      primed_q;

    logic [NUM_PORTS-1:0][7:0] deb_eff, rep, ev, stat_base, stat_nxt, port_out_v;
    logic [NUM_PORTS-1:0]      accept, snap_load;

    logic [4:0] bank;
    logic [2:0] port_sel;
    logic       port_ok;

    state_t      state_q, state_nxt;
    logic [15:0] gap_q, gap_nxt;
    logic        any_stat;

    assign bank     = iOffset[7:3];
    assign port_sel = iOffset[2:0];
    assign port_ok  = {1'b0, port_sel} < NP;

`ifdef IOEXP_POLARITY_EN
    logic [NUM_PORTS-1:0][7:0] pol_q;

    always_ff @(posedge iClk or negedge nrst) begin
        if (!nrst) begin
            pol_q <= '0;
        end else if (iWrEn && port_ok && bank == BK_POL) begin
            for (int p = 0; p < NUM_PORTS; p++)
                if (port_sel == 3'(p)) pol_q[p] <= iWrData;
        end
    end

    assign pol_v = pol_q;
`else
    assign pol_v = '0;
`endif

    // Debounce counter holds the remaining stable cycles; a change reloads it with the full count.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            deb_eff[p]   = (sync2_q[p] != deb_last_q[p]) ? DEB : deb_cnt_q[p];
            accept[p]    = (deb_eff[p] == 8'd1);
            rep[p]       = filt_q[p] ^ pol_v[p];
            ev[p]        = (accept[p] && primed_q[p]) ?
                           ((filt_q[p] ^ sync2_q[p]) & cfg_q[p] & ~mask_q[p]) : 8'h00;
            stat_base[p] = (iRdEn && port_ok && bank == BK_IN && port_sel == 3'(p)) ?
                           8'h00 : stat_q[p];
            stat_nxt[p]  = stat_base[p] | ev[p];
            snap_load[p] = (stat_base[p] == 8'h00) && (ev[p] != 8'h00);
            port_out_v[p] = (cfg_q[p] & rep[p]) | (~cfg_q[p] & out_q[p]);
        end
    end

    assign oPortOut = port_out_v;

    always_ff @(posedge iClk or negedge nrst) begin
        if (!nrst) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_last_q <= '1;
            deb_cnt_q  <= {NUM_PORTS{DEB}};
            filt_q     <= '1;
            primed_q   <= '0;
            out_q      <= '1;
            cfg_q      <= '1;
            mask_q     <= '0;
            stat_q     <= '0;
            snap_q     <= '1;
        end else begin
            sync1_q    <= iPortIn;
            sync2_q    <= sync1_q;
            deb_last_q <= sync2_q;
            stat_q     <= stat_nxt;
            for (int p = 0; p < NUM_PORTS; p++) begin
                deb_cnt_q[p] <= (deb_eff[p] != 8'd0) ? deb_eff[p] - 8'd1 : 8'd0;
                if (accept[p]) begin
                    filt_q[p]   <= sync2_q[p];
                    primed_q[p] <= 1'b1;
                end
                // Snapshot captures the newly accepted value, so a same-cycle clear+event reloads it.
                if (snap_load[p]) snap_q[p] <= sync2_q[p] ^ pol_v[p];
                if (iWrEn && port_ok && port_sel == 3'(p)) begin
                    if (bank == BK_OUT)  out_q[p]  <= iWrData;
                    if (bank == BK_CFG)  cfg_q[p]  <= iWrData;
                    if (bank == BK_MASK) mask_q[p] <= iWrData;
                end
            end
        end
    end

    always_comb begin
        oRdData = 8'hFF;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_sel == 3'(p)) begin
                case (bank)
                    BK_IN:   oRdData = (stat_q[p] != 8'h00) ? snap_q[p] : rep[p];
                    BK_OUT:  oRdData = out_q[p];
                    BK_POL:  oRdData = pol_v[p];
                    BK_CFG:  oRdData = cfg_q[p];
                    BK_MASK: oRdData = mask_q[p];
                    BK_STAT: oRdData = stat_q[p];
                    default: oRdData = 8'hFF;
                endcase
            end
        end
    end

    assign any_stat = |stat_q;

    always_ff @(posedge iClk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            oInt_n  <= 1'b1;
        end else begin
            state_q <= state_nxt;
            gap_q   <= gap_nxt;
            oInt_n  <= (state_q == ST_ASSERT) ? ~iIntDisable_n : 1'b1;
        end
    end

    always_comb begin
        state_nxt = state_q;
        gap_nxt   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (any_stat) state_nxt = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (!any_stat) begin
                    state_nxt = ST_GAP;
                    gap_nxt   = GAP;
                end
            end
            ST_GAP: begin
                gap_nxt = gap_q - 16'd1;
                if (gap_q == 16'd1) state_nxt = any_stat ? ST_ASSERT : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
